// File: rtl/fp_div_arbiter.sv
// Round-robin arbiter that lends one iterative FP divider (run/stall handshake)
// to NREQ requesters and returns each quotient over a valid/ready response channel.
module fp_div_arbiter #(
  parameter int NREQ    = 2,
  parameter int TIMEOUT = 40
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [32*NREQ-1:0]   req_x,
  input  logic [32*NREQ-1:0]   req_y,
  output logic [NREQ-1:0]      rsp_valid,
  input  logic [NREQ-1:0]      rsp_ready,
  output logic [31:0]          rsp_z,
  output logic                 rsp_err,
  output logic                 div_run,
  output logic [31:0]          div_x,
  output logic [31:0]          div_y,
  input  logic                 div_stall,
  input  logic [31:0]          div_z,
  output logic                 busy
);

  // state  | meaning
  // S_IDLE | granting: combinational one-hot req_ready from the rotating pointer
  // S_RUN  | divider running on held operands, watchdog counting
  // S_RESP | result (or abort) presented to the owner until it is consumed
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_RESP} state_t;

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_t          r_state;
  logic [IW-1:0]   r_rr_ptr;
  logic [IW-1:0]   r_owner;
  logic [CW-1:0]   r_cnt;
  logic [31:0]     r_div_x;
  logic [31:0]     r_div_y;
  logic [31:0]     r_rsp_z;
  logic            r_div_run;
  logic            r_rsp_err;

  logic            w_found;
  logic [IW-1:0]   w_grant_id;
  logic [31:0]     w_sel_x;
  logic [31:0]     w_sel_y;
  logic [NREQ-1:0] w_grant;
  logic [NREQ-1:0] w_owner_oh;

  // Scan from the pointer, wrapping modulo NREQ; first valid requester wins.
  always_comb begin
    w_found    = 1'b0;
    w_grant_id = '0;
    w_sel_x    = '0;
    w_sel_y    = '0;
    w_grant    = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!w_found && req_valid[(int'(r_rr_ptr) + k) % NREQ]) begin
        w_found    = 1'b1;
        w_grant_id = IW'((int'(r_rr_ptr) + k) % NREQ);
        w_sel_x    = req_x[32*((int'(r_rr_ptr) + k) % NREQ) +: 32];
        w_sel_y    = req_y[32*((int'(r_rr_ptr) + k) % NREQ) +: 32];
      end
    end
    if (w_found) w_grant[w_grant_id] = 1'b1;
  end

  always_comb begin
    w_owner_oh          = '0;
    w_owner_oh[r_owner] = 1'b1;
  end

  // Gated by rst so the grant is silent while reset is held, even with requests pending.
  assign req_ready = (r_state == S_IDLE && rst) ? w_grant : '0;
  assign rsp_valid = (r_state == S_RESP) ? w_owner_oh : '0;
  assign busy      = (r_state != S_IDLE);
  assign div_run   = r_div_run;
  assign div_x     = r_div_x;
  assign div_y     = r_div_y;
  assign rsp_z     = r_rsp_z;
  assign rsp_err   = r_rsp_err;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_rr_ptr  <= '0;
      r_owner   <= '0;
      r_cnt     <= '0;
      r_div_x   <= '0;
      r_div_y   <= '0;
      r_rsp_z   <= '0;
      r_div_run <= 1'b0;
      r_rsp_err <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_div_x   <= w_sel_x;
            r_div_y   <= w_sel_y;
            r_owner   <= w_grant_id;
            r_rr_ptr  <= (w_grant_id == IW'(NREQ-1)) ? '0 : w_grant_id + 1'b1;
            r_div_run <= 1'b1;
            r_cnt     <= '0;
            r_state   <= S_RUN;
          end
        end
        S_RUN: begin
          r_cnt <= r_cnt + 1'b1;
          if (!div_stall) begin
            r_rsp_z   <= div_z;
            r_rsp_err <= 1'b0;
            r_div_run <= 1'b0;
            r_state   <= S_RESP;
          end else if (r_cnt == CW'(TIMEOUT-1)) begin
            r_rsp_z   <= '0;
            r_rsp_err <= 1'b1;
            r_div_run <= 1'b0;
            r_state   <= S_RESP;
          end
        end
        S_RESP: begin
          if (|(rsp_ready & w_owner_oh)) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
